// File: rtl/elastic_pipe_chain.sv
// rtl/elastic_pipe_chain.sv - parametrised valid/ready register chain with flush and optional input skid
module elastic_pipe_chain #(
  parameter int WIDTH     = 64,
  parameter int STAGES    = 5,
  parameter int REG_READY = 1,
  parameter int OCC_W     = $clog2(STAGES + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STAGES-1:0] flush,
  input  logic              flush_all,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [STAGES-1:0] stage_valid,
  output logic [OCC_W-1:0]  occupancy
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic              skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0]  skid_data_q, skid_data_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic [STAGES:0]   ready;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] fill;
  logic              accept;
  logic              src_valid;
  logic [WIDTH-1:0]  src_data;
  logic              out_xfer;
  logic [OCC_W-1:0]  flush_cnt;

  // A slot can take a new entry if it is empty, its occupant is being killed, or it moves on.
  always_comb begin
    ready = '0;
    ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = !valid_q[k] | flush[k] | (ready[k+1] & !flush[k]);
    end
  end

  always_comb begin
    in_ready     = 1'b0;
    accept       = 1'b0;
    src_valid    = 1'b0;
    src_data     = in_data;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (REG_READY != 0) begin
      in_ready  = rst & !flush_all & !skid_valid_q;
      accept    = in_valid & in_ready;
      // The parked entry always goes ahead of fresh input to keep FIFO order.
      src_valid = skid_valid_q | accept;
      src_data  = skid_valid_q ? skid_data_q : in_data;
      if (skid_valid_q && ready[0]) begin
        skid_valid_d = 1'b0;
      end else if (accept && !ready[0]) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else begin
      in_ready  = rst & !flush_all & ready[0];
      accept    = in_valid & in_ready;
      src_valid = accept;
    end
    if (flush_all) begin
      skid_valid_d = 1'b0;
    end
  end

  always_comb begin
    adv  = '0;
    fill = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = valid_q[k] & !flush[k] & ready[k+1] & !flush_all;
    end
    fill[0] = src_valid & ready[0] & !flush_all;
    for (int k = 1; k < STAGES; k++) begin
      fill[k] = adv[k-1];
    end

    valid_d = valid_q;
    data_d  = data_q;
    if (fill[0]) begin
      data_d[0] = src_data;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (fill[k]) begin
        data_d[k] = data_q[k-1];
      end
    end
    // An arrival wins over a flush of the same slot: flush only targets the current occupant.
    for (int k = 0; k < STAGES; k++) begin
      if (fill[k]) begin
        valid_d[k] = 1'b1;
      end else if (flush[k] || adv[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    if (flush_all) begin
      valid_d = '0;
    end
  end

  assign out_valid   = rst & valid_q[STAGES-1] & !flush[STAGES-1] & !flush_all;
  assign out_xfer    = out_valid & out_ready;
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = valid_q;
  assign occupancy   = occ_q;

  always_comb begin
    flush_cnt = '0;
    for (int k = 0; k < STAGES; k++) begin
      flush_cnt = flush_cnt + OCC_W'(valid_q[k] & flush[k]);
    end
    if (flush_all) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(accept) - OCC_W'(out_xfer) - flush_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      occ_q        <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      occ_q        <= occ_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// tb/tb_elastic_pipe_chain.sv - scoreboard bench for elastic_pipe_chain (STAGES=5, WIDTH=64, REG_READY=1)
module tb_elastic_pipe_chain;

  localparam int W  = 64;
  localparam int S  = 5;
  localparam int OW = $clog2(S + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [S-1:0]  flush;
  logic          flush_all;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [S-1:0]  stage_valid;
  logic [OW-1:0] occupancy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [$];

  elastic_pipe_chain #(.WIDTH(W), .STAGES(S), .REG_READY(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .flush_all(flush_all),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stage_valid(stage_valid), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d required 0", occupancy); end
    checks++; if (stage_valid !== 5'b0) begin errors++; $display("FAIL rst_stage_valid got %b required 00000", stage_valid); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b required 1", in_ready); end
    next_cycle();
  endtask

  task automatic test_streaming();
    int idx = 1;
    int first_acc = -1;
    int first_out = -1;
    logic [W-1:0] exp;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && (idx <= 16 || exp_q.size() > 0); c++) begin
      in_valid = (idx <= 16);
      in_data  = W'(idx);
      @(negedge clk);
      if (in_valid) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready got %b required 1", in_ready); end
      end
      if (c >= 5 && c <= 15) begin
        checks++; if (occupancy !== 3'd5) begin errors++; $display("FAIL stream_occ cycle %0d got %0d required 5", c, occupancy); end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(W'(idx));
        if (first_acc < 0) first_acc = c;
        idx++;
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = c;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stream_extra got %h required none", out_data); end
        else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin errors++; $display("FAIL stream_data got %h required %h", out_data, exp); end
        end
      end
      next_cycle();
    end
    in_valid = 1'b0;
    checks++; if (first_out - first_acc != S) begin errors++; $display("FAIL stream_latency got %0d required %0d", first_out - first_acc, S); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain left %0d required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    logic [W-1:0] exp;
    out_ready = 1'b0;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      in_valid = 1'b1;
      in_data  = W'(64'hA + 64'(idx));
      @(negedge clk);
      if (in_valid && in_ready) begin exp_q.push_back(in_data); idx++; end
      next_cycle();
    end
    in_valid = 1'b0;
    checks++; if (idx != 6) begin errors++; $display("FAIL bp_fill got %0d required 6", idx); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (out_data !== 64'hA) begin errors++; $display("FAIL bp_out_data got %h required a", out_data); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b required 1", out_valid); end
      checks++; if (occupancy !== 3'd6) begin errors++; $display("FAIL bp_occ got %0d required 6", occupancy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b required 0", in_ready); end
      next_cycle();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        exp = exp_q.pop_front();
        checks++; if (out_data !== exp) begin errors++; $display("FAIL bp_drain_data got %h required %h", out_data, exp); end
      end
      next_cycle();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain left %0d required 0", exp_q.size()); end
    @(negedge clk);
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL bp_occ_end got %0d required 0", occupancy); end
    next_cycle();
  endtask

  task automatic test_bubble();
    logic [W-1:0] exp;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 0 || c == 4);
      in_data  = (c == 0) ? 64'h1 : 64'h2;
      @(negedge clk);
      if (c == 4) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready got %b required 1", in_ready); end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (stage_valid !== 5'b11000) begin errors++; $display("FAIL bubble_stage_valid got %b required 11000", stage_valid); end
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL bubble_occ got %0d required 2", occupancy); end
    checks++; if (out_data !== 64'h1) begin errors++; $display("FAIL bubble_out_data got %h required 1", out_data); end
    next_cycle();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        exp = exp_q.pop_front();
        checks++; if (out_data !== exp) begin errors++; $display("FAIL bubble_drain_data got %h required %h", out_data, exp); end
      end
      next_cycle();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bubble_drain left %0d required 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    int idx = 1;
    logic [W-1:0] exp;
    out_ready = 1'b0;
    for (int c = 0; c < 20 && idx <= 5; c++) begin
      in_valid = 1'b1;
      in_data  = W'(idx);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      next_cycle();
    end
    in_valid = 1'b0;
    exp_q = {};
    exp_q.push_back(64'h1);
    exp_q.push_back(64'h2);
    exp_q.push_back(64'h5);
    @(negedge clk);
    checks++; if (stage_valid !== 5'b11111) begin errors++; $display("FAIL flush_pre_valid got %b required 11111", stage_valid); end
    checks++; if (occupancy !== 3'd5) begin errors++; $display("FAIL flush_pre_occ got %0d required 5", occupancy); end
    next_cycle();
    flush     = 5'b00110;
    out_ready = 1'b1;
    @(negedge clk);
    if (out_valid && out_ready) begin
      exp = exp_q.pop_front();
      checks++; if (out_data !== exp) begin errors++; $display("FAIL flush_cycle_data got %h required %h", out_data, exp); end
    end
    next_cycle();
    flush = 5'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL flush_occ got %0d required 2", occupancy); end
        checks++; if (stage_valid !== 5'b10010) begin errors++; $display("FAIL flush_stage_valid got %b required 10010", stage_valid); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL flush_extra got %h required none", out_data); end
        else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin errors++; $display("FAIL flush_data got %h required %h", out_data, exp); end
        end
      end
      next_cycle();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flush_drain left %0d required 0", exp_q.size()); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leftover got %b required 0", out_valid); end
    next_cycle();
  endtask

  task automatic test_flush_all();
    int idx = 0;
    int leaks = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      in_valid = 1'b1;
      in_data  = W'(64'h40 + 64'(idx));
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (occupancy !== 3'd6) begin errors++; $display("FAIL fa_pre_occ got %0d required 6", occupancy); end
    next_cycle();
    flush_all = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h77;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fa_in_ready got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fa_out_valid got %b required 0", out_valid); end
    next_cycle();
    flush_all = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    checks++; if (stage_valid !== 5'b0) begin errors++; $display("FAIL fa_stage_valid got %b required 00000", stage_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fa_occ got %0d required 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fa_in_ready_after got %b required 1", in_ready); end
    next_cycle();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) leaks++;
      next_cycle();
    end
    checks++; if (leaks != 0) begin errors++; $display("FAIL fa_leak got %0d outputs required 0", leaks); end
  endtask

  task automatic test_reset_mid();
    int first_acc = -1;
    int first_out = -1;
    int early = 0;
    logic [W-1:0] exp;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = W'(64'h30 + 64'(c));
      @(negedge clk);
      if (out_valid) early++;
      next_cycle();
    end
    in_valid = 1'b0;
    checks++; if (early != 0) begin errors++; $display("FAIL rm_early_out got %0d required 0", early); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_in_ready got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %b required 0", out_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rm_occ got %0d required 0", occupancy); end
    checks++; if (stage_valid !== 5'b0) begin errors++; $display("FAIL rm_stage_valid got %b required 00000", stage_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_in_ready_low got %b required 0", in_ready); end
    rst = 1'b1;
    next_cycle();
    exp_q = {};
    for (int c = 0; c < 20; c++) begin
      in_valid = (first_acc < 0);
      in_data  = 64'h20;
      @(negedge clk);
      if (in_valid && in_ready) begin exp_q.push_back(in_data); first_acc = c; end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = c;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rm_extra got %h required none", out_data); end
        else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin errors++; $display("FAIL rm_data got %h required %h", out_data, exp); end
        end
      end
      next_cycle();
    end
    in_valid = 1'b0;
    checks++; if (first_acc < 0 || first_out - first_acc != S) begin errors++; $display("FAIL rm_latency got %0d required %0d", first_out - first_acc, S); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_drain left %0d required 0", exp_q.size()); end
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = '0;
    flush_all = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_flush_all();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
